// File: rtl/seq_signed_divider.sv
// Sequential 32/16 signed divider: one restoring step per cycle, truncating quotient.
// Ports: clk, rst (async low), dividend, divisor, start -> quotient, remainder, done, busy, ovf, div0.
module seq_signed_divider (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] dividend,
  input  logic signed [15:0] divisor,
  input  logic               start,
  output logic signed [15:0] quotient,
  output logic signed [15:0] remainder,
  output logic               done,
  output logic               busy,
  output logic               ovf,
  output logic               div0
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [32:0] q;
  logic [16:0] r;
  logic [16:0] d;
  logic        sa;
  logic        sb;
  logic        z;

  logic [32:0] a_ext;
  logic [32:0] a_mag;
  logic [16:0] b_ext;
  logic [16:0] b_mag;
  logic [17:0] trial;
  logic [17:0] diff;
  logic signed [33:0] q_s;
  logic [15:0] r_s;
  logic        q_hi;
  logic        q_lo;

  assign busy = (state != IDLE);

  // Magnitudes are one bit wider than the operands so that
  // -2^31 and -2^15 negate without wrapping.
  assign a_ext = {dividend[31], dividend};
  assign a_mag = dividend[31] ? 33'd0 - a_ext : a_ext;
  assign b_ext = {divisor[15], divisor};
  assign b_mag = divisor[15] ? 17'd0 - b_ext : b_ext;

  // |dividend| <= 2^31, so only q[31:0] carries data; q[32] stays 0.
  assign trial = {r, q[31]};
  assign diff  = trial - {1'b0, d};

  always_comb begin
    q_s = $signed({1'b0, q});
    if (sa ^ sb) q_s = -q_s;
  end

  assign q_hi = (q_s > 34'sd32767);
  assign q_lo = (q_s < -34'sd32768);
  assign r_s  = sa ? 16'd0 - r[15:0] : r[15:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      r         <= '0;
      d         <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      z         <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            q     <= a_mag;
            r     <= '0;
            d     <= b_mag;
            sa    <= dividend[31];
            sb    <= divisor[15];
            z     <= (divisor == 16'sd0);
            cnt   <= 5'd31;
            state <= CALC;
          end
        end
        CALC: begin
          if (z) begin
            state <= FIX;
          end else begin
            if (!diff[17]) begin
              r <= diff[16:0];
              q <= {1'b0, q[30:0], 1'b1};
            end else begin
              r <= trial[16:0];
              q <= {1'b0, q[30:0], 1'b0};
            end
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= FIX;
          end
        end
        FIX: begin
          if (z) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            div0      <= 1'b1;
          end else begin
            unique case (1'b1)
              q_hi:    quotient <= 16'sh7fff;
              q_lo:    quotient <= -16'sh8000;
              default: quotient <= q_s[15:0];
            endcase
            remainder <= r_s;
            ovf       <= q_hi | q_lo;
            div0      <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
